// File: rtl/atta_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atta_wb_pkg
// Description : Shared Wishbone definitions: default bus widths and the
//               grant state encoding used by the bus arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package atta_wb_pkg;

    // Default bus geometry shared by all Wishbone blocks in the system
    localparam int c_WB_ADDR_WIDTH = 32;
    localparam int c_WB_DATA_WIDTH = 32;

    // Arbiter grant state: either nobody owns the bus or one master does
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               upward from last+1 (with wrap) and returns the first
//               requester as a one-hot vector plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_pick
    import atta_wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last,
    output logic [NUM_MASTERS-1:0] o_winner,
    output logic                   o_valid
);

    logic [IDX_W-1:0] w_idx;

    // Rotating scan: the previous owner is visited last, so it has lowest priority
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_idx = IDX_W'((int'(i_last) + i) % NUM_MASTERS);
            if (!o_valid && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                o_valid         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Round-robin Wishbone B3 classic arbiter sharing one slave
//               port between NUM_MASTERS masters. Ownership lasts a whole
//               cyc (no preemption); a stall watchdog terminates hung beats
//               with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter
    import atta_wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = c_WB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = c_WB_DATA_WIDTH,
    parameter int TIMEOUT     = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_MASTERS-1:0]             m_cyc_i,
    input  logic [NUM_MASTERS-1:0]             m_stb_i,
    input  logic [NUM_MASTERS-1:0]             m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    output logic [DATA_WIDTH-1:0]              m_dat_o,
    output logic [NUM_MASTERS-1:0]             m_ack_o,
    output logic [NUM_MASTERS-1:0]             m_err_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [ADDR_WIDTH-1:0]              s_adr_o,
    output logic [DATA_WIDTH-1:0]              s_dat_o,
    output logic [DATA_WIDTH/8-1:0]            s_sel_o,
    input  logic [DATA_WIDTH-1:0]              s_dat_i,
    input  logic                               s_ack_i,
    input  logic                               s_err_i,
    output logic [NUM_MASTERS-1:0]             grant_o
);

    localparam int c_SEL_WIDTH = DATA_WIDTH / 8;
    localparam int c_IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t               r_state;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [c_IDX_W-1:0]       r_last;
    logic [c_WD_W-1:0]        r_wd_cnt;

    logic [NUM_MASTERS-1:0]   w_pick_onehot;
    logic                     w_pick_valid;
    logic [c_IDX_W-1:0]       w_pick_idx;
    logic                     w_cyc_mux;
    logic                     w_stb_mux;
    logic                     w_we_mux;
    logic                     w_wd_err;
    logic                     w_wd_count;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_pick (
        .i_req    (m_cyc_i),
        .i_last   (r_last),
        .o_winner (w_pick_onehot),
        .o_valid  (w_pick_valid)
    );

    // Convert the picker's one-hot winner into an index to remember as 'last'
    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_pick_onehot[k]) begin
                w_pick_idx = c_IDX_W'(k);
            end
        end
    end

    // Grant FSM: grant on any request from IDLE, release only when the owner drops cyc
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= c_IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ARB_OWN;
                        r_grant <= w_pick_onehot;
                        r_last  <= w_pick_idx;
                    end
                end
                ARB_OWN: begin
                    if (!w_cyc_mux) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Route the granted master's slice to the slave; grant is zero in IDLE so all outputs are zero
    always_comb begin
        w_cyc_mux = 1'b0;
        w_stb_mux = 1'b0;
        w_we_mux  = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_cyc_mux = m_cyc_i[k];
                w_stb_mux = m_stb_i[k];
                w_we_mux  = m_we_i[k];
                s_adr_o   = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o   = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o   = m_sel_i[k*c_SEL_WIDTH +: c_SEL_WIDTH];
            end
        end
    end

    // The terminated beat is hidden from the slave so it cannot complete late
    assign s_cyc_o = w_cyc_mux;
    assign s_stb_o = w_stb_mux & ~w_wd_err;
    assign s_we_o  = w_we_mux;

    // Responses go only to the owner; read data is broadcast unconditionally
    assign m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
    assign m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_wd_err}};
    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;

    // A beat is stalled while strobe is up and the slave has not responded
    assign w_wd_count = (r_state == ARB_OWN) && s_stb_o && !s_ack_i && !s_err_i;

    generate
        if (TIMEOUT > 0) begin : g_wd_on
            assign w_wd_err = (r_state == ARB_OWN) && (r_wd_cnt == c_WD_W'(TIMEOUT));
        end else begin : g_wd_off
            assign w_wd_err = 1'b0;
        end
    endgenerate

    // Watchdog counter: advances on stalled beats, clears on any response, idle or fired error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wd_cnt <= '0;
        end else if (w_wd_count && (TIMEOUT > 0)) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_rr_arbiter
// Description : Directed self-checking bench for wb_rr_arbiter (2 masters,
//               watchdog limit of 8 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk      = 1'b0;
    logic            rst_i    = 1'b1;
    logic [N-1:0]    m_cyc_i  = '0;
    logic [N-1:0]    m_stb_i  = '0;
    logic [N-1:0]    m_we_i   = '0;
    logic [N*AW-1:0] m_adr_i  = '0;
    logic [N*DW-1:0] m_dat_i  = '0;
    logic [N*SW-1:0] m_sel_i  = '0;
    logic [DW-1:0]   s_dat_i  = '0;
    logic            s_err_i  = 1'b0;
    logic            man_ack  = 1'b0;
    logic            auto_ack = 1'b0;

    wire  [DW-1:0]   m_dat_o;
    wire  [N-1:0]    m_ack_o;
    wire  [N-1:0]    m_err_o;
    wire             s_cyc_o;
    wire             s_stb_o;
    wire             s_we_o;
    wire  [AW-1:0]   s_adr_o;
    wire  [DW-1:0]   s_dat_o;
    wire  [SW-1:0]   s_sel_o;
    wire  [N-1:0]    grant_o;
    wire             s_ack_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model: either acks every visible strobe at once, or is driven by hand
    assign s_ack_i = auto_ack ? s_stb_o : man_ack;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .grant_o (grant_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Contention and no-preemption vectors, one row per cycle:
    // {m_cyc (=m_stb), expected grant, expected m_ack, expected s_cyc}
    logic [6:0] vec [23] = '{
        7'b11_00_00_0, 7'b11_10_10_1, 7'b01_10_00_0, 7'b11_00_00_0,
        7'b11_01_01_1, 7'b10_01_00_0, 7'b11_00_00_0, 7'b11_10_10_1,
        7'b01_10_00_0, 7'b11_00_00_0, 7'b11_01_01_1, 7'b00_01_00_0,
        7'b00_00_00_0,
        7'b01_00_00_0, 7'b01_01_01_1, 7'b11_01_01_1, 7'b11_01_01_1,
        7'b11_01_01_1, 7'b10_01_00_0, 7'b10_00_00_0, 7'b10_10_10_1,
        7'b00_10_00_0, 7'b00_00_00_0
    };

    initial begin
        #100000;
        $display("FAIL global_timeout: observed time %0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        s_dat_i = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_scyc",  64'(s_cyc_o), 64'h0);
        chk("rst_sstb",  64'(s_stb_o), 64'h0);
        chk("rst_ack",   64'(m_ack_o), 64'h0);
        chk("rst_err",   64'(m_err_o), 64'h0);
        chk("rst_dat",   64'(m_dat_o), 64'h1234_5678);
        nxt();
        rst_i = 1'b0;

        // ---------------- single master read ----------------
        nxt();
        m_adr_i[0 +: AW] = 32'h0000_0100;
        m_sel_i[0 +: SW] = 4'hF;
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        @(negedge clk);
        chk("single_scyc_lat", 64'(s_cyc_o), 64'h0);
        nxt();
        @(negedge clk);
        chk("single_scyc",  64'(s_cyc_o), 64'h1);
        chk("single_grant", 64'(grant_o), 64'h1);
        chk("single_adr",   64'(s_adr_o), 64'h100);
        chk("single_noack", 64'(m_ack_o), 64'h0);
        nxt();
        man_ack = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("single_ack",   64'(m_ack_o), 64'h1);
        chk("single_dat",   64'(m_dat_o), 64'hDEAD_BEEF);
        chk("single_grant2", 64'(grant_o), 64'h1);
        nxt();
        man_ack = 1'b0;
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        nxt();
        @(negedge clk);
        chk("single_release", 64'(grant_o), 64'h0);

        // ---------------- contention + no preemption ----------------
        auto_ack = 1'b1;
        for (int i = 0; i < 23; i++) begin
            nxt();
            m_cyc_i = vec[i][6:5];
            m_stb_i = vec[i][6:5];
            @(negedge clk);
            chk($sformatf("arb_grant[%0d]", i), 64'(grant_o), 64'(vec[i][4:3]));
            chk($sformatf("arb_ack[%0d]", i),   64'(m_ack_o), 64'(vec[i][2:1]));
            chk($sformatf("arb_scyc[%0d]", i),  64'(s_cyc_o), 64'(vec[i][0]));
        end
        auto_ack = 1'b0;

        // ---------------- watchdog on m1 write ----------------
        nxt();
        m_adr_i[AW +: AW] = 32'h0000_0200;
        m_dat_i[DW +: DW] = 32'hCAFE_F00D;
        m_sel_i[SW +: SW] = 4'h3;
        m_we_i  = 2'b10;
        m_cyc_i = 2'b10;
        m_stb_i = 2'b10;
        @(negedge clk);
        chk("wd_grant0", 64'(grant_o), 64'h0);
        nxt();
        @(negedge clk);
        chk("wd_grant", 64'(grant_o), 64'h2);
        chk("wd_we",    64'(s_we_o),  64'h1);
        chk("wd_adr",   64'(s_adr_o), 64'h200);
        chk("wd_dat",   64'(s_dat_o), 64'hCAFE_F00D);
        chk("wd_sel",   64'(s_sel_o), 64'h3);
        chk("wd_stb1",  64'(s_stb_o), 64'h1);
        for (int k = 2; k <= 8; k++) begin
            nxt();
            @(negedge clk);
            chk($sformatf("wd_wait_err[%0d]", k), 64'(m_err_o), 64'h0);
            chk($sformatf("wd_wait_stb[%0d]", k), 64'(s_stb_o), 64'h1);
        end
        nxt();
        @(negedge clk);
        chk("wd_fire_err", 64'(m_err_o), 64'h2);
        chk("wd_fire_stb", 64'(s_stb_o), 64'h0);
        chk("wd_fire_ack", 64'(m_ack_o), 64'h0);
        nxt();
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        m_we_i  = 2'b00;
        @(negedge clk);
        chk("wd_after_err", 64'(m_err_o), 64'h0);
        nxt();
        @(negedge clk);
        chk("wd_release", 64'(grant_o), 64'h0);

        // ---------------- ack at the watchdog limit ----------------
        nxt();
        m_adr_i[0 +: AW] = 32'h0000_0300;
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            nxt();
            @(negedge clk);
            chk($sformatf("lim_wait_err[%0d]", k), 64'(m_err_o), 64'h0);
        end
        nxt();
        man_ack = 1'b1;
        @(negedge clk);
        chk("lim_ack", 64'(m_ack_o), 64'h1);
        chk("lim_err", 64'(m_err_o), 64'h0);
        nxt();
        man_ack = 1'b0;
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        @(negedge clk);
        chk("lim_after_err", 64'(m_err_o), 64'h0);
        chk("lim_after_ack", 64'(m_ack_o), 64'h0);
        nxt();
        @(negedge clk);
        chk("lim_release", 64'(grant_o), 64'h0);

        // ---------------- asynchronous reset mid-transaction ----------------
        nxt();
        m_cyc_i = 2'b01;
        m_stb_i = 2'b01;
        nxt();
        man_ack = 1'b1;
        @(negedge clk);
        chk("ar_pre_ack",   64'(m_ack_o), 64'h1);
        chk("ar_pre_grant", 64'(grant_o), 64'h1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("ar_scyc",  64'(s_cyc_o), 64'h0);
        chk("ar_grant", 64'(grant_o), 64'h0);
        chk("ar_ack",   64'(m_ack_o), 64'h0);
        chk("ar_err",   64'(m_err_o), 64'h0);
        man_ack = 1'b0;
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        nxt();
        nxt();
        rst_i = 1'b0;
        @(negedge clk);
        chk("ar_rel_grant", 64'(grant_o), 64'h0);
        nxt();
        @(negedge clk);
        chk("ar_first_grant", 64'(grant_o), 64'h1);
        chk("ar_first_scyc",  64'(s_cyc_o), 64'h1);
        nxt();
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        repeat (3) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
